modsq_iter_wrapper: RTL and testbench

MODSQ_ITER_WRAPPER -- requirements
Module: modsq_iter_wrapper

---
 rtl/modsq_iter_if.sv | 39 +++
 rtl/modsq_iter_wrapper.sv | 160 ++++++++++++++++
 tb/tb_modsq_iter_wrapper.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/modsq_iter_if.sv
// Purpose : bundles the host-side and core-side signals of the iterated modular squaring wrapper.
// Latency : none (wires only).
// Backpressure: none; the core iterates autonomously and every result is accepted.
// Ports   : host side  start/abort/iterations/sq_in -> busy/sq_out/valid/done/iter_count
//           core side  core_start/core_sq_in -> core_sq_out/core_valid
//           master = host + core model, slave = wrapper.
interface modsq_iter_if #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int BIT_LEN            = 17,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int OUT_WORD_LEN       = 32,
    parameter int ITER_W             = 32
);
    logic                               start;
    logic                               abort;
    logic [ITER_W-1:0]                  iterations;
    logic [MOD_LEN-1:0]                 sq_in;
    logic                               busy;
    logic [NUM_ELEMENTS*OUT_WORD_LEN-1:0] sq_out;
    logic                               valid;
    logic                               done;
    logic [ITER_W-1:0]                  iter_count;
    logic                               core_start;
    logic [NUM_ELEMENTS*BIT_LEN-1:0]    core_sq_in;
    logic [NUM_ELEMENTS*BIT_LEN-1:0]    core_sq_out;
    logic                               core_valid;

    modport master (
        output start, abort, iterations, sq_in, core_sq_out, core_valid,
        input  busy, sq_out, valid, done, iter_count, core_start, core_sq_in
    );

    modport slave (
        input  start, abort, iterations, sq_in, core_sq_out, core_valid,
        output busy, sq_out, valid, done, iter_count, core_start, core_sq_in
    );
endinterface

// File: rtl/modsq_iter_wrapper.sv
// Purpose : sequences N squarings on an autonomous modular squaring core, splitting the input into coefficients and packing results.
// Latency : core_start IO_STAGES cycles after start; each core result appears on sq_out/valid IO_STAGES cycles after core_valid.
// Backpressure: none; results beyond the requested count are masked, abort flushes both pipes.
// Ports   : clk, reset (async, active high), bus (modsq_iter_if.slave) carrying host and core signals.
module modsq_iter_wrapper #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int BIT_LEN            = 17,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int IO_STAGES          = 3,
    parameter int OUT_WORD_LEN       = 32,
    parameter int ITER_W             = 32
) (
    input  logic         clk,
    input  logic         reset,
    modsq_iter_if.slave  bus
);
    localparam int NONRED = MOD_LEN / WORD_LEN;
    localparam int CW     = NUM_ELEMENTS * BIT_LEN;
    localparam int SQW    = NUM_ELEMENTS * OUT_WORD_LEN;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t                        state;
    logic                          busy_q;
    logic                          done_q;
    logic [ITER_W-1:0]             iter_target;
    logic [ITER_W-1:0]             core_cnt;
    logic [ITER_W-1:0]             iter_count_q;
    logic [IO_STAGES-1:0]          in_vld;
    logic [IO_STAGES-1:0]          out_vld;
    logic [IO_STAGES-1:0][CW-1:0]  in_dat;
    logic [IO_STAGES-1:0][CW-1:0]  out_dat;

    logic [CW-1:0]                 split_in;
    logic [SQW-1:0]                sq_out_w;
    logic                          start_acc;
    logic                          zero_start;
    logic                          core_acc;
    logic                          abort_now;
    logic                          emit_in;
    logic                          final_emit;

    // Coefficient split: 16-bit words zero-extended into 17-bit slots, redundant top slots stay zero.
    always_comb begin
        split_in = '0;
        for (int j = 0; j < NONRED; j++) begin
            split_in[j*BIT_LEN +: BIT_LEN] = BIT_LEN'(bus.sq_in[j*WORD_LEN +: WORD_LEN]);
        end
    end

    // Output packing from the last output stage, which doubles as the sq_out holding register.
    always_comb begin
        sq_out_w = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            sq_out_w[j*OUT_WORD_LEN +: OUT_WORD_LEN] =
                OUT_WORD_LEN'(out_dat[IO_STAGES-1][j*BIT_LEN +: BIT_LEN]);
        end
    end

    assign start_acc  = (state == IDLE) && bus.start && (bus.iterations != '0);
    assign zero_start = (state == IDLE) && bus.start && (bus.iterations == '0);
    assign core_acc   = (state == RUN) && bus.core_valid;
    assign abort_now  = busy_q && bus.abort;

    // emit_in: an entry is about to land in the last output stage on this edge.
    if (IO_STAGES == 1) begin : g_emit_direct
        assign emit_in = core_acc;
    end else begin : g_emit_piped
        assign emit_in = out_vld[IO_STAGES-2];
    end

    // Counting delivered results rather than core results keeps done aligned with the last valid.
    assign final_emit = emit_in && (iter_count_q == iter_target - ITER_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            iter_target  <= '0;
            core_cnt     <= '0;
            iter_count_q <= '0;
            in_vld       <= '0;
            out_vld      <= '0;
            in_dat       <= '0;
            out_dat      <= '0;
        end else if (abort_now) begin
            // Flush in-flight work; sq_out, iter_count and core_sq_in keep their values.
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            in_vld  <= '0;
            out_vld <= '0;
        end else begin
            done_q <= 1'b0;

            // Input pipe: data moves only with its valid so core_sq_in holds after FILL.
            in_vld[0] <= start_acc;
            if (start_acc) in_dat[0] <= split_in;
            for (int k = 1; k < IO_STAGES; k++) begin
                in_vld[k] <= in_vld[k-1];
                if (in_vld[k-1]) in_dat[k] <= in_dat[k-1];
            end

            // Output pipe: only results accepted in RUN are ever pushed.
            out_vld[0] <= core_acc;
            if (core_acc) out_dat[0] <= bus.core_sq_out;
            for (int k = 1; k < IO_STAGES; k++) begin
                out_vld[k] <= out_vld[k-1];
                if (out_vld[k-1]) out_dat[k] <= out_dat[k-1];
            end

            if (emit_in) begin
                iter_count_q <= iter_count_q + ITER_W'(1);
                if (final_emit) done_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state        <= FILL;
                        busy_q       <= 1'b1;
                        iter_target  <= bus.iterations;
                        core_cnt     <= '0;
                        iter_count_q <= '0;
                    end else if (zero_start) begin
                        done_q <= 1'b1;
                    end
                end
                FILL: begin
                    // core_start is visible this cycle; the core can answer from next cycle on.
                    if (in_vld[IO_STAGES-1]) state <= RUN;
                end
                RUN: begin
                    if (core_acc) begin
                        core_cnt <= core_cnt + ITER_W'(1);
                        if (core_cnt == iter_target - ITER_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done_q) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.valid      = out_vld[IO_STAGES-1];
    assign bus.iter_count = iter_count_q;
    assign bus.sq_out     = sq_out_w;
    assign bus.core_start = in_vld[IO_STAGES-1];
    assign bus.core_sq_in = in_dat[IO_STAGES-1];
endmodule

// File: tb/tb_modsq_iter_wrapper.sv
// Purpose : directed self-checking bench for modsq_iter_wrapper with a cycle-scripted core model.
// Latency : each scenario is a fixed number of cycles counted from the start cycle (cycle 0).
// Backpressure: not applicable; the bench records per-cycle pulse masks and compares them to hand-derived masks.
module tb_modsq_iter_wrapper;
    localparam int MOD_LEN = 1024;
    localparam int BIT_LEN = 17;
    localparam int NE      = 66;
    localparam int OWL     = 32;
    localparam int ITER_W  = 32;
    localparam int CW      = NE * BIT_LEN;
    localparam int SQW     = NE * OWL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modsq_iter_if bus ();

    modsq_iter_wrapper dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0]       vld_m, done_m, cs_m, busy_m;
    logic [CW-1:0]     cs_dat;
    logic [ITER_W-1:0] done_ic;
    int                rst_ones;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Core result pattern for cycle c: every coefficient tagged with cycle and index, bit 16 set.
    function automatic logic [CW-1:0] pat(input int c);
        logic [CW-1:0] v;
        v = '0;
        for (int j = 0; j < NE; j++) begin
            v[j*BIT_LEN +: BIT_LEN] = 17'h10000 | 17'((c & 8'hFF) << 8) | 17'(j);
        end
        return v;
    endfunction

    function automatic logic [SQW-1:0] expand(input logic [CW-1:0] v);
        logic [SQW-1:0] r;
        r = '0;
        for (int j = 0; j < NE; j++) begin
            r[j*OWL +: OWL] = {15'd0, v[j*BIT_LEN +: BIT_LEN]};
        end
        return r;
    endfunction

    // Called at posedge+1; cycle c inputs are applied then, outputs sampled 2 ns later.
    task automatic run(input logic [ITER_W-1:0] iters, input logic [MOD_LEN-1:0] sin,
                       input logic [63:0] cv, input int ab_c, input int st2_c,
                       input int rst_c, input int n);
        vld_m = '0; done_m = '0; cs_m = '0; busy_m = '0;
        cs_dat = '0; done_ic = '0; rst_ones = -1;
        for (int c = 0; c < n; c++) begin
            bus.start       = (c == 0) || (c == st2_c);
            bus.iterations  = iters;
            bus.sq_in       = sin;
            bus.abort       = (c == ab_c);
            bus.core_valid  = cv[c];
            bus.core_sq_out = pat(c);
            reset           = (c == rst_c);
            #2;
            busy_m[c] = bus.busy;
            if (bus.valid)      vld_m[c]  = 1'b1;
            if (bus.done)       begin done_m[c] = 1'b1; done_ic = bus.iter_count; end
            if (bus.core_start) begin cs_m[c] = 1'b1; cs_dat = bus.core_sq_in; end
            if (c == rst_c)
                rst_ones = $countones({bus.busy, bus.valid, bus.done, bus.core_start,
                                       bus.iter_count, bus.sq_out, bus.core_sq_in});
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.core_valid = 1'b0; reset = 1'b0;
    endtask

    logic [MOD_LEN-1:0] s5;
    logic [CW-1:0]      e5;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.core_valid = 1'b0;
        bus.iterations = '0; bus.sq_in = '0; bus.core_sq_out = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",       64'(bus.busy), 64'd0);
        chk("rst_valid",      64'(bus.valid), 64'd0);
        chk("rst_done",       64'(bus.done), 64'd0);
        chk("rst_core_start", 64'(bus.core_start), 64'd0);
        chk("rst_iter_count", 64'(bus.iter_count), 64'd0);
        chk("rst_sq_out_ones",     64'($countones(bus.sq_out)), 64'd0);
        chk("rst_core_sq_in_ones", 64'($countones(bus.core_sq_in)), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Three iterations, core answers at 10/20/30.
        run(32'd3, 1024'h5, (64'd1<<10)|(64'd1<<20)|(64'd1<<30), -1, -1, -1, 40);
        chk("s1_core_start", cs_m, 64'd1<<3);
        chk("s1_core_sq_in_diff", 64'($countones(cs_dat ^ CW'(5))), 64'd0);
        chk("s1_valid", vld_m, (64'd1<<13)|(64'd1<<23)|(64'd1<<33));
        chk("s1_done", done_m, 64'd1<<33);
        chk("s1_done_iter_count", 64'(done_ic), 64'd3);
        chk("s1_busy", busy_m, ((64'd1<<34)-64'd1) ^ 64'd1);
        chk("s1_sq_out_diff", 64'($countones(bus.sq_out ^ expand(pat(30)))), 64'd0);
        chk("s1_iter_count_hold", 64'(bus.iter_count), 64'd3);

        // Zero iterations: immediate done, nothing else moves.
        run(32'd0, 1024'h7, 64'd0, -1, -1, -1, 6);
        chk("s2_done", done_m, 64'd1<<1);
        chk("s2_core_start", cs_m, 64'd0);
        chk("s2_busy", busy_m, 64'd0);
        chk("s2_valid", vld_m, 64'd0);
        chk("s2_sq_out_hold", 64'($countones(bus.sq_out ^ expand(pat(30)))), 64'd0);

        // Two iterations, extra core results masked, core_valid in FILL ignored.
        run(32'd2, 1024'h9, (64'd1<<2)|(64'd1<<10)|(64'd1<<11)|(64'd1<<12)|(64'd1<<13), -1, -1, -1, 20);
        chk("s3_valid", vld_m, (64'd1<<13)|(64'd1<<14));
        chk("s3_done", done_m, 64'd1<<14);
        chk("s3_done_iter_count", 64'(done_ic), 64'd2);
        chk("s3_sq_out_diff", 64'($countones(bus.sq_out ^ expand(pat(11)))), 64'd0);

        // Abort mid-run after one delivered result.
        run(32'd5, 1024'h3, (64'd1<<10)|(64'd1<<20), 22, -1, -1, 30);
        chk("s4_valid", vld_m, 64'd1<<13);
        chk("s4_done", done_m, 64'd0);
        chk("s4_busy", busy_m, ((64'd1<<23)-64'd1) ^ 64'd1);
        chk("s4_iter_count", 64'(bus.iter_count), 64'd1);
        chk("s4_sq_out_hold", 64'($countones(bus.sq_out ^ expand(pat(10)))), 64'd0);

        // Second start while busy ignored; start+abort in IDLE starts; multi-word split.
        s5 = '0;
        s5[31:16]     = 16'hABCD;
        s5[1023:1008] = 16'hFFFF;
        e5 = '0;
        e5[1*BIT_LEN +: BIT_LEN]  = 17'h0ABCD;
        e5[63*BIT_LEN +: BIT_LEN] = 17'h0FFFF;
        run(32'd1, s5, 64'd1<<10, 0, 5, -1, 20);
        chk("s5_core_start", cs_m, 64'd1<<3);
        chk("s5_core_sq_in_diff", 64'($countones(cs_dat ^ e5)), 64'd0);
        chk("s5_core_sq_in_hold", 64'($countones(bus.core_sq_in ^ e5)), 64'd0);
        chk("s5_valid", vld_m, 64'd1<<13);
        chk("s5_done", done_m, 64'd1<<13);
        chk("s5_done_iter_count", 64'(done_ic), 64'd1);

        // Reset mid-run at cycle 15 with a coincident start that must be lost.
        run(32'd3, 1024'h5, (64'd1<<10)|(64'd1<<20), -1, 15, 15, 30);
        chk("s6_reset_outputs_ones", 64'(rst_ones), 64'd0);
        chk("s6_valid", vld_m, 64'd1<<13);
        chk("s6_done", done_m, 64'd0);
        chk("s6_busy", busy_m, ((64'd1<<15)-64'd1) ^ 64'd1);
        chk("s6_core_start", cs_m, 64'd1<<3);
        chk("s6_sq_out_ones", 64'($countones(bus.sq_out)), 64'd0);
        chk("s6_iter_count", 64'(bus.iter_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
